// File: rtl/repairclk_pattern_detector_if.sv
// Enable, lane samples and result signals between the REPAIRCLK partner logic
// (master) and the receive-side pattern detector (slave).
interface repairclk_pattern_detector_if;
    logic       i_MBINIT_REPAIRCLK_Detection_en;
    logic       i_RCKP;
    logic       i_RCKN;
    logic       i_RTRK;
    logic [2:0] o_Clock_track_result_logged;
    logic       o_CLK_Track_done;
    logic       o_detect_busy;

    modport master (
        output i_MBINIT_REPAIRCLK_Detection_en,
        output i_RCKP,
        output i_RCKN,
        output i_RTRK,
        input  o_Clock_track_result_logged,
        input  o_CLK_Track_done,
        input  o_detect_busy
    );

    modport slave (
        input  i_MBINIT_REPAIRCLK_Detection_en,
        input  i_RCKP,
        input  i_RCKN,
        input  i_RTRK,
        output o_Clock_track_result_logged,
        output o_CLK_Track_done,
        output o_detect_busy
    );
endinterface

// File: rtl/repairclk_pattern_detector.sv
// MBINIT.REPAIRCLK receive checker: aligns to the first high lane sample, scores each
// toggle/idle iteration per lane and logs a sticky pass flag for {RTRK,RCKN,RCKP}.
module repairclk_pattern_detector #(
    parameter int TOGGLE_LEN = 32,
    parameter int IDLE_LEN   = 16,
    parameter int ITERATIONS = 128,
    parameter int PASS_ITER  = 16,
    parameter int TIMEOUT    = 4096
) (
    input logic                         CLK,
    input logic                         rst_n,
    repairclk_pattern_detector_if.slave det
);

    // state | meaning
    // IDLE  | waiting for detection enable
    // ARMED | window open, waiting for the first high sample on any lane
    // CHECK | scoring lane samples against the toggle/idle pattern
    // DONE  | one-cycle done pulse, result final
    // HOLD  | result held until enable drops
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_DONE,
        S_HOLD
    } state_t;

    localparam int PERIOD = TOGGLE_LEN + IDLE_LEN;
    localparam int PH_W   = $clog2(PERIOD);
    localparam int IT_W   = $clog2(ITERATIONS + 1);
    localparam int CS_W   = $clog2(PASS_ITER + 1);
    localparam int TO_W   = $clog2(TIMEOUT);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] PH_TOG   = PH_W'(TOGGLE_LEN);
    localparam logic [IT_W-1:0] IT_LAST  = IT_W'(ITERATIONS - 1);
    localparam logic [CS_W-1:0] CS_PASS  = CS_W'(PASS_ITER);
    localparam logic [CS_W-1:0] CS_PREV  = CS_W'(PASS_ITER - 1);
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q;
    logic [IT_W-1:0] iter_q;
    logic [TO_W-1:0] tmo_q;
    logic [CS_W-1:0] consec_q [3];
    logic [2:0]      mism_q;
    logic [2:0]      pass_q;

    logic            en;
    logic [2:0]      lanes;
    logic            exp_bit;
    logic            last_phase;
    logic [2:0]      mism_now;
    logic            start;
    logic            abort;
    logic            sample_en;

    assign en         = det.i_MBINIT_REPAIRCLK_Detection_en;
    assign lanes      = {det.i_RTRK, det.i_RCKN, det.i_RCKP};
    assign last_phase = (phase_q == PH_LAST);
    assign exp_bit    = (phase_q < PH_TOG) ? ~phase_q[0] : 1'b0;
    // includes the current sample, so the last phase counts toward its own iteration
    assign mism_now   = mism_q | (lanes ^ {3{exp_bit}});

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ARMED;
                    start   = 1'b1;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end else if (|lanes) begin
                    state_d   = S_CHECK;
                    sample_en = 1'b1;
                end else if (tmo_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                if (!en) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end else begin
                    sample_en = 1'b1;
                    if (last_phase && (iter_q == IT_LAST)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_HOLD;
            S_HOLD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            iter_q  <= '0;
            tmo_q   <= '0;
            mism_q  <= '0;
            pass_q  <= '0;
            for (int l = 0; l < 3; l++) begin
                consec_q[l] <= '0;
            end
        end else if (start || abort) begin
            phase_q <= '0;
            iter_q  <= '0;
            tmo_q   <= TO_LOAD;
            mism_q  <= '0;
            pass_q  <= '0;
            for (int l = 0; l < 3; l++) begin
                consec_q[l] <= '0;
            end
        end else if (sample_en) begin
            if (last_phase) begin
                phase_q <= '0;
                iter_q  <= iter_q + IT_W'(1);
                mism_q  <= '0;
                for (int l = 0; l < 3; l++) begin
                    if (mism_now[l]) begin
                        consec_q[l] <= '0;
                    end else begin
                        if (consec_q[l] != CS_PASS) begin
                            consec_q[l] <= consec_q[l] + CS_W'(1);
                        end
                        if (consec_q[l] >= CS_PREV) begin
                            pass_q[l] <= 1'b1;
                        end
                    end
                end
            end else begin
                phase_q <= phase_q + PH_W'(1);
                mism_q  <= mism_now;
            end
        end else if ((state_q == S_ARMED) && (tmo_q != '0)) begin
            tmo_q <= tmo_q - TO_W'(1);
        end
    end

    assign det.o_Clock_track_result_logged = pass_q;
    assign det.o_CLK_Track_done            = (state_q == S_DONE);
    assign det.o_detect_busy               = (state_q == S_ARMED) || (state_q == S_CHECK);

endmodule

// File: tb/tb_repairclk_pattern_detector.sv
// Randomized directed windows for the REPAIRCLK pattern detector, scored against a
// per-iteration clean/run-length model of the lane pattern rules.
module tb_repairclk_pattern_detector;
    localparam int TOG  = 32;
    localparam int PER  = 48;
    localparam int ITER = 128;
    localparam int PASS = 16;
    localparam int TMO  = 4096;
    localparam int WIN  = PER * ITER;

    logic CLK = 1'b0;
    logic rst_n;

    repairclk_pattern_detector_if bus ();

    repairclk_pattern_detector dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .det   (bus)
    );

    always #5 CLK = ~CLK;

    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;
    bit         pat [3][WIN];
    int         pass_iter [3];
    logic [2:0] final_res;

    function automatic bit ideal(int k);
        int p;
        p = k % PER;
        return (p < TOG) && (p % 2 == 0);
    endfunction

    function automatic logic [4:0] outs();
        return {bus.o_Clock_track_result_logged, bus.o_CLK_Track_done, bus.o_detect_busy};
    endfunction

    task automatic check(string tag, logic [4:0] obs, logic [4:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed result/done/busy=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(bit p, bit n, bit t);
        bus.i_RCKP = p;
        bus.i_RCKN = n;
        bus.i_RTRK = t;
    endtask

    // mode: 0 ideal, 1 stuck low, 2 one flip every 10th iteration, 3 garbage before
    // iteration arg, 4 one-sample skew, 5 garbage from iteration arg, 6 random flips (1/arg)
    task automatic gen_lane(int l, int mode, int arg);
        int it;
        int k2;
        for (int k = 0; k < WIN; k++) begin
            it = k / PER;
            case (mode)
                1:       pat[l][k] = 1'b0;
                3:       pat[l][k] = (it < arg) ? 1'($urandom_range(0, 1)) : ideal(k);
                4:       pat[l][k] = (k == 0) ? 1'b0 : ideal(k - 1);
                5:       pat[l][k] = (it >= arg) ? 1'($urandom_range(0, 1)) : ideal(k);
                default: pat[l][k] = ideal(k);
            endcase
        end
        if (mode == 2 || mode == 6) begin
            for (int i = 0; i < ITER; i++) begin
                if ((mode == 2 && i % 10 == 9) || (mode == 6 && $urandom_range(0, arg - 1) == 0)) begin
                    k2 = i * PER + int'($urandom_range(0, PER - 1));
                    pat[l][k2] = ~pat[l][k2];
                end
            end
        end
    endtask

    task automatic build_model();
        int run;
        bit clean;
        if (!(pat[0][0] || pat[1][0] || pat[2][0])) pat[0][0] = 1'b1;
        for (int l = 0; l < 3; l++) begin
            run = 0;
            pass_iter[l] = -1;
            for (int it = 0; it < ITER; it++) begin
                clean = 1'b1;
                for (int p = 0; p < PER; p++) begin
                    if (pat[l][it * PER + p] != ideal(it * PER + p)) clean = 1'b0;
                end
                run = clean ? run + 1 : 0;
                if (run == PASS && pass_iter[l] < 0) pass_iter[l] = it;
            end
            final_res[l] = (pass_iter[l] >= 0);
        end
    endtask

    function automatic logic [2:0] live_res(int k);
        logic [2:0] r;
        for (int l = 0; l < 3; l++) begin
            r[l] = (pass_iter[l] >= 0) && (k >= pass_iter[l] * PER + PER - 1);
        end
        return r;
    endfunction

    // stop_k < 0: full window; otherwise enable drops before sample stop_k
    task automatic run_window(string name, int gap, int stop_k);
        int last_k;
        last_k = (stop_k < 0) ? WIN : stop_k;
        set_lanes(1'b0, 1'b0, 1'b0);
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b1;
        @(posedge CLK); #1;
        check({name, " arm"}, outs(), 5'b000_0_1);
        for (int g = 0; g < gap; g++) begin
            @(posedge CLK); #1;
            check({name, " armed wait"}, outs(), 5'b000_0_1);
        end
        for (int k = 0; k < last_k; k++) begin
            set_lanes(pat[0][k], pat[1][k], pat[2][k]);
            @(posedge CLK); #1;
            check({name, " window"}, outs(), {live_res(k), k == WIN - 1, k != WIN - 1});
        end
        set_lanes(1'b0, 1'b0, 1'b0);
        if (stop_k >= 0) begin
            bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge CLK); #1;
                check({name, " aborted"}, outs(), 5'b000_0_0);
            end
        end else begin
            @(posedge CLK); #1;
            check({name, " hold"}, outs(), {final_res, 2'b00});
            bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b0;
            @(posedge CLK); #1;
            check({name, " idle keeps result"}, outs(), {final_res, 2'b00});
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b0;
        set_lanes(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset values", outs(), 5'b000_0_0);
        rst_n = 1'b1;
        @(posedge CLK); #1;
        check("idle after reset", outs(), 5'b000_0_0);

        // 1: all lanes ideal
        for (int l = 0; l < 3; l++) gen_lane(l, 0, 0);
        build_model();
        run_window("ideal", int'($urandom_range(0, 30)), -1);

        // 2: RCKN stuck low
        gen_lane(0, 0, 0); gen_lane(1, 1, 0); gen_lane(2, 0, 0);
        build_model();
        run_window("rckn stuck", int'($urandom_range(0, 30)), -1);

        // 3: RTRK corrupted every 10th iteration
        gen_lane(0, 0, 0); gen_lane(1, 0, 0); gen_lane(2, 2, 0);
        build_model();
        run_window("rtrk corrupt", int'($urandom_range(0, 30)), -1);

        // 4: RCKP clean only from iteration 100
        gen_lane(0, 3, 100); gen_lane(1, 0, 0); gen_lane(2, 0, 0);
        build_model();
        run_window("rckp late", int'($urandom_range(0, 30)), -1);

        // 5: no activity until timeout
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b1;
        set_lanes(1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        check("timeout arm", outs(), 5'b000_0_1);
        for (int c = 1; c <= TMO; c++) begin
            @(posedge CLK); #1;
            check("timeout wait", outs(), {3'b000, c == TMO, c != TMO});
        end
        @(posedge CLK); #1;
        check("timeout hold", outs(), 5'b000_0_0);
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b0;
        @(posedge CLK); #1;
        check("timeout idle", outs(), 5'b000_0_0);

        // 6: abort at iteration 50, then a clean window
        for (int l = 0; l < 3; l++) gen_lane(l, 0, 0);
        build_model();
        run_window("abort", int'($urandom_range(0, 10)), 50 * PER + int'($urandom_range(0, PER - 1)));
        run_window("after abort", int'($urandom_range(0, 10)), -1);

        // 7: late garbage after pass, skewed lane, sparse flips
        gen_lane(0, 5, 60); gen_lane(1, 4, 0); gen_lane(2, 6, 30);
        build_model();
        run_window("mixed", int'($urandom_range(0, 30)), -1);

        // 8: fully random lane modes
        for (int l = 0; l < 3; l++) begin
            int m;
            m = int'($urandom_range(0, 6));
            gen_lane(l, m, (m == 3) ? int'($urandom_range(80, 120)) :
                           (m == 5) ? int'($urandom_range(10, 120)) : int'($urandom_range(3, 40)));
        end
        build_model();
        run_window("random", int'($urandom_range(0, 30)), -1);

        // reset mid-CHECK with passes already logged
        for (int l = 0; l < 3; l++) gen_lane(l, 0, 0);
        build_model();
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 1000; k++) begin
            set_lanes(pat[0][k], pat[1][k], pat[2][k]);
            @(posedge CLK); #1;
        end
        check("pre-reset pass", outs(), 5'b111_0_1);
        #3 rst_n = 1'b0;
        #1;
        check("async reset", outs(), 5'b000_0_0);
        bus.i_MBINIT_REPAIRCLK_Detection_en = 1'b0;
        set_lanes(1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;
        check("post-reset idle", outs(), 5'b000_0_0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
